// File: rtl/fip_pkg.sv
// Shared constants, state encoding and operand payload for the fixed-point divider arbiter.
package fip_pkg;

  localparam int unsigned FIP_FRA_BITS = 16;
  localparam logic [31:0] FIP_MAX      = 32'h7FFF_FFFF;
  localparam logic [31:0] FIP_MIN      = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } fip_state_e;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
  } fip_op_t;

  // Two's-complement magnitude; 32'h80000000 maps to its unsigned value 2^31.
  function automatic logic [31:0] fip_abs(input logic [31:0] v);
    return v[31] ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/fip_32_div_iter.sv
// Restoring shift-subtract divider on magnitudes, one quotient bit per cycle; sign applied on the last bit.
// Build option: FIP_DIV_SAT_EN clamps out-of-range quotients instead of wrapping.
module fip_32_div_iter
  import fip_pkg::*;
#(
  parameter int unsigned FRA_BITS = FIP_FRA_BITS
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  fip_op_t     i_op,
  output logic        o_busy,
  output logic        o_done_c,
  output logic [31:0] o_z_c,
  output logic        o_dbz_c
);

  localparam int unsigned DW = 32 + FRA_BITS;
  localparam int unsigned CW = $clog2(DW);

  // acc_q starts as the scaled dividend and fills with quotient bits from the bottom
  logic [DW-1:0] acc_q;
  logic [31:0]   rem_q;
  logic [31:0]   dvsr_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q;
  logic          xneg_q;
  logic          dbz_q;
  logic [32:0]   rem_sh;
  logic [31:0]   rem_d;
  logic [31:0]   q_lo;
  logic          qbit;

  assign o_done_c = o_busy && (cnt_q == CW'(DW - 1));
  assign o_dbz_c  = dbz_q;

  always_comb begin
    rem_sh = {rem_q, acc_q[DW-1]};
    qbit   = (rem_sh >= {1'b0, dvsr_q});
    rem_d  = qbit ? 32'(rem_sh - {1'b0, dvsr_q}) : rem_sh[31:0];
  end

  // Final result, valid while o_done_c: quotient including the bit being produced this cycle.
  always_comb begin
    q_lo  = {acc_q[30:0], qbit};
    o_z_c = q_lo;
    if (dbz_q) begin
      o_z_c = xneg_q ? FIP_MIN : FIP_MAX;
    end
`ifdef FIP_DIV_SAT_EN
    else if (!neg_q && ((|acc_q[DW-2:31]) || q_lo[31])) begin
      o_z_c = FIP_MAX;
    end else if (neg_q && ((|acc_q[DW-2:31]) || (q_lo[31] && (|q_lo[30:0])))) begin
      o_z_c = FIP_MIN;
    end
`endif
    else begin
      o_z_c = neg_q ? 32'(~q_lo + 32'd1) : q_lo;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      xneg_q <= 1'b0;
      dbz_q  <= 1'b0;
      o_busy <= 1'b0;
    end else if (i_start) begin
      acc_q  <= {fip_abs(i_op.x), {FRA_BITS{1'b0}}};
      rem_q  <= '0;
      dvsr_q <= fip_abs(i_op.y);
      cnt_q  <= '0;
      neg_q  <= i_op.x[31] ^ i_op.y[31];
      xneg_q <= i_op.x[31];
      dbz_q  <= (i_op.y == 32'd0);
      o_busy <= 1'b1;
    end else if (o_busy) begin
      acc_q <= {acc_q[DW-2:0], qbit};
      rem_q <= rem_d;
      cnt_q <= cnt_q + CW'(1);
      if (o_done_c) o_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fip_32_div_arb.sv
// Round-robin arbiter sharing one iterative Q-format divider among N_REQ requesters.
// Build option: define FIP_DIV_SAT_EN to saturate overflowing quotients (default wraps).
module fip_32_div_arb
  import fip_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned FRA_BITS = FIP_FRA_BITS
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [N_REQ-1:0]              i_req_valid,
  output logic [N_REQ-1:0]              o_req_ready,
  input  logic signed [N_REQ-1:0][31:0] i_req_x,
  input  logic signed [N_REQ-1:0][31:0] i_req_y,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [$clog2(N_REQ)-1:0]      o_rsp_id,
  output logic signed [31:0]            o_rsp_z,
  output logic                          o_rsp_dbz
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  fip_state_e      state_q;
  fip_state_e      state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_vld;
  logic            accept;
  fip_op_t         div_op;
  logic            div_busy;
  logic            div_done_c;
  logic [31:0]     div_z_c;
  logic            div_dbz_c;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = 32'(rr_ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_vld && i_req_valid[ID_W'(j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

  always_comb begin
    div_op.x = i_req_x[gnt_idx];
    div_op.y = i_req_y[gnt_idx];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Ready is a same-cycle grant so an accept happens on the edge it is seen.
  always_comb begin
    state_d     = state_q;
    o_req_ready = '0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rstn && gnt_vld && !div_busy) begin
          o_req_ready[gnt_idx] = 1'b1;
          accept               = 1'b1;
          state_d              = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rr_ptr_q    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_z     <= '0;
      o_rsp_dbz   <= 1'b0;
    end else begin
      o_rsp_valid <= (state_d == ST_DONE);
      if (accept) begin
        rr_ptr_q <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        o_rsp_id <= gnt_idx;
      end
      if (div_done_c) begin
        o_rsp_z   <= div_z_c;
        o_rsp_dbz <= div_dbz_c;
      end
    end
  end

  fip_32_div_iter #(
    .FRA_BITS (FRA_BITS)
  ) u_div (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_start  (accept),
    .i_op     (div_op),
    .o_busy   (div_busy),
    .o_done_c (div_done_c),
    .o_z_c    (div_z_c),
    .o_dbz_c  (div_dbz_c)
  );

endmodule

// File: tb/tb_fip_32_div_arb.sv
// Self-checking bench for fip_32_div_arb: directed vectors, random ops against an arithmetic model,
// round-robin ordering with response backpressure, and reset in the middle of a division.
module tb_fip_32_div_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned FRA = 16;
  localparam int          LAT = 32 + FRA;

  logic                      i_clk = 1'b0;
  logic                      i_rstn;
  logic [N-1:0]              i_req_valid;
  logic [N-1:0]              o_req_ready;
  logic signed [N-1:0][31:0] i_req_x;
  logic signed [N-1:0][31:0] i_req_y;
  logic                      o_rsp_valid;
  logic                      i_rsp_ready;
  logic [1:0]                o_rsp_id;
  logic signed [31:0]        o_rsp_z;
  logic                      o_rsp_dbz;

  int n_cmp = 0;
  int n_err = 0;

  fip_32_div_arb #(.N_REQ(N), .FRA_BITS(FRA)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_x     (i_req_x),
    .i_req_y     (i_req_y),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_z     (o_rsp_z),
    .o_rsp_dbz   (o_rsp_dbz)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  // Reference: exact signed quotient of x*2^FRA / y, truncated toward zero, then wrap or clamp.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y, output logic dbz);
    longint num;
    longint q;
    if (y == 32'd0) begin
      dbz = 1'b1;
      return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    dbz = 1'b0;
    num = longint'($signed(x)) * (longint'(1) <<< FRA);
    q   = num / longint'($signed(y));
`ifdef FIP_DIV_SAT_EN
    if (q > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (q < -64'sd2147483648) return 32'h8000_0000;
`endif
    return q[31:0];
  endfunction

  // Drives one request on requester k alone, measures accept-to-valid edges, consumes the response.
  task automatic run_one(input int k, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] z, output logic [1:0] id, output logic dbz,
                         output int lat, output bit to);
    int n;
    to  = 1'b0;
    lat = 0;
    z   = '0;
    id  = '0;
    dbz = 1'b0;
    i_req_valid    = '0;
    i_req_valid[k] = 1'b1;
    i_req_x[k]     = x;
    i_req_y[k]     = y;
    #1;
    n = 0;
    while (o_req_ready[k] !== 1'b1) begin
      if (n == 200) begin
        to = 1'b1;
        i_req_valid = '0;
        return;
      end
      @(posedge i_clk); #1;
      n++;
    end
    @(posedge i_clk); #1;
    i_req_valid = '0;
    i_req_x[k]  = $urandom;
    i_req_y[k]  = $urandom;
    do begin
      @(posedge i_clk); #1;
      lat++;
    end while (o_rsp_valid !== 1'b1 && lat < 200);
    if (o_rsp_valid !== 1'b1) begin
      to = 1'b1;
      return;
    end
    z   = o_rsp_z;
    id  = o_rsp_id;
    dbz = o_rsp_dbz;
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rstn      = 1'b1;
    i_req_valid = '0;
    i_req_x     = '0;
    i_req_y     = '0;
    i_rsp_ready = 1'b0;
    #3 i_rstn = 1'b0;
    i_req_valid = '1;
    repeat (3) @(posedge i_clk);
    #1;
    n_cmp++; if (o_req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", o_req_ready); end
    n_cmp++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_rsp_valid); end
    n_cmp++; if (o_rsp_z !== 32'd0) begin n_err++; $display("FAIL reset_z: got %h want 0", o_rsp_z); end
    n_cmp++; if (o_rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", o_rsp_id); end
    n_cmp++; if (o_rsp_dbz !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", o_rsp_dbz); end
    i_req_valid = '0;
    i_rstn      = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_round_robin();
    logic [31:0] ox [N];
    logic [31:0] oy [N];
    logic [31:0] ez;
    logic [31:0] z0;
    logic [1:0]  id0;
    logic        d0;
    logic        edbz;
    logic [3:0]  erdy;
    int          n;
    int          lat;
    for (int i = 0; i < int'(N); i++) begin
      ox[i] = $urandom;
      oy[i] = 32'($urandom_range(1, 1 << 20));
      i_req_x[i] = ox[i];
      i_req_y[i] = oy[i];
    end
    i_req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (o_req_ready === '0 && n < 300) begin
        @(posedge i_clk); #1;
        n++;
      end
      erdy = 4'(1) << (g % 4);
      n_cmp++; if (o_req_ready !== erdy) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", g, o_req_ready, erdy); end
      @(posedge i_clk); #1;
      lat = 0;
      do begin
        @(posedge i_clk); #1;
        lat++;
      end while (o_rsp_valid !== 1'b1 && lat < 200);
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL rr_latency%0d: got %0d want %0d", g, lat, LAT); end
      ez = ref_div(ox[g % 4], oy[g % 4], edbz);
      n_cmp++; if (o_rsp_id !== 2'(g % 4)) begin n_err++; $display("FAIL rr_id%0d: got %0d want %0d", g, o_rsp_id, g % 4); end
      n_cmp++; if (o_rsp_z !== ez) begin n_err++; $display("FAIL rr_z%0d: got %h want %h", g, o_rsp_z, ez); end
      if (g == 0) begin
        z0  = o_rsp_z;
        id0 = o_rsp_id;
        d0  = o_rsp_dbz;
        for (int c = 0; c < 10; c++) begin
          @(posedge i_clk); #1;
          n_cmp++;
          if (o_rsp_valid !== 1'b1 || o_rsp_z !== z0 || o_rsp_id !== id0 || o_rsp_dbz !== d0 || o_req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL rr_hold%0d: valid=%b z=%h id=%0d dbz=%b ready=%b want valid=1 z=%h id=%0d dbz=%b ready=0000",
                     c, o_rsp_valid, o_rsp_z, o_rsp_id, o_rsp_dbz, o_req_ready, z0, id0, d0);
          end
        end
      end
      i_rsp_ready = 1'b1;
      @(posedge i_clk); #1;
      i_rsp_ready = 1'b0;
    end
    i_req_valid = '0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_known();
    logic [31:0] z;
    logic [1:0]  id;
    logic        dbz;
    int          lat;
    bit          to;
    logic [31:0] wrap_exp;

    run_one(0, 32'h0006_0000, 32'h0002_0000, z, id, dbz, lat, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL k_basic_timeout: got timeout want response"); end
    n_cmp++; if (lat !== 48) begin n_err++; $display("FAIL k_basic_latency: got %0d want 48", lat); end
    n_cmp++; if (z !== 32'h0003_0000) begin n_err++; $display("FAIL k_basic_z: got %h want 00030000", z); end
    n_cmp++; if (id !== 2'd0) begin n_err++; $display("FAIL k_basic_id: got %0d want 0", id); end
    n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL k_basic_dbz: got %b want 0", dbz); end

    run_one(1, 32'hFFFE_8000, 32'h0000_8000, z, id, dbz, lat, to);
    n_cmp++; if (to || z !== 32'hFFFD_0000) begin n_err++; $display("FAIL k_neg_z: got %h (timeout=%0d) want fffd0000", z, to); end
    n_cmp++; if (id !== 2'd1) begin n_err++; $display("FAIL k_neg_id: got %0d want 1", id); end

    run_one(2, 32'h0001_0000, 32'h0000_0000, z, id, dbz, lat, to);
    n_cmp++; if (to || z !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL k_dbz_pos_z: got %h want 7fffffff", z); end
    n_cmp++; if (dbz !== 1'b1) begin n_err++; $display("FAIL k_dbz_pos_flag: got %b want 1", dbz); end
    n_cmp++; if (lat !== 48) begin n_err++; $display("FAIL k_dbz_latency: got %0d want 48", lat); end

    run_one(3, 32'hFFFF_0000, 32'h0000_0000, z, id, dbz, lat, to);
    n_cmp++; if (to || z !== 32'h8000_0000) begin n_err++; $display("FAIL k_dbz_neg_z: got %h want 80000000", z); end
    n_cmp++; if (dbz !== 1'b1) begin n_err++; $display("FAIL k_dbz_neg_flag: got %b want 1", dbz); end

`ifdef FIP_DIV_SAT_EN
    wrap_exp = 32'h7FFF_FFFF;
`else
    wrap_exp = 32'h0000_0000;
`endif
    run_one(0, 32'h4000_0000, 32'h0000_0100, z, id, dbz, lat, to);
    n_cmp++; if (to || z !== wrap_exp) begin n_err++; $display("FAIL k_overflow_z: got %h want %h", z, wrap_exp); end
    n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL k_overflow_dbz: got %b want 0", dbz); end
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] ez;
    logic [1:0]  id;
    logic        dbz;
    logic        edbz;
    int          lat;
    int          k;
    bit          to;
    for (int t = 0; t < 24; t++) begin
      k = $urandom_range(0, N - 1);
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 4096));
        2: begin x = 32'($signed(x) >>> 10); y = $urandom; end
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) y = 32'(-y);
      ez = ref_div(x, y, edbz);
      run_one(k, x, y, z, id, dbz, lat, to);
      n_cmp++; if (to || lat !== LAT) begin n_err++; $display("FAIL rnd%0d_latency: got %0d (timeout=%0d) want %0d", t, lat, to, LAT); end
      n_cmp++; if (z !== ez) begin n_err++; $display("FAIL rnd%0d_z: x=%h y=%h got %h want %h", t, x, y, z, ez); end
      n_cmp++; if (dbz !== edbz) begin n_err++; $display("FAIL rnd%0d_dbz: got %b want %b", t, dbz, edbz); end
      n_cmp++; if (id !== 2'(k)) begin n_err++; $display("FAIL rnd%0d_id: got %0d want %0d", t, id, k); end
    end
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  seen;
    i_req_valid    = '0;
    i_req_valid[2] = 1'b1;
    i_req_x[2]     = 32'h0006_0000;
    i_req_y[2]     = 32'h0002_0000;
    #1;
    n = 0;
    while (o_req_ready[2] !== 1'b1 && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    n_cmp++; if (o_req_ready[2] !== 1'b1) begin n_err++; $display("FAIL mid_grant2: got %b want 0100", o_req_ready); end
    @(posedge i_clk); #1;
    i_req_valid = '0;
    repeat (20) @(posedge i_clk);
    #1;
    i_rstn      = 1'b0;
    i_req_valid = 4'b1001;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0000", o_req_ready); end
    n_cmp++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", o_rsp_valid); end
    n_cmp++; if (o_rsp_z !== 32'd0) begin n_err++; $display("FAIL mid_rst_z: got %h want 0", o_rsp_z); end
    n_cmp++; if (o_rsp_id !== 2'd0) begin n_err++; $display("FAIL mid_rst_id: got %0d want 0", o_rsp_id); end
    n_cmp++; if (o_rsp_dbz !== 1'b0) begin n_err++; $display("FAIL mid_rst_dbz: got %b want 0", o_rsp_dbz); end
    @(posedge i_clk);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_next_grant: got %b want 0001", o_req_ready); end
    i_req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge i_clk); #1;
      if (o_rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL mid_no_response: got valid=1 want no response"); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_known();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
